vec_len_sqrt: RTL and testbench
===============================

Name: vec_len_sqrt

Overview:
- Sequential fixed-point square root stage directly downstream of the squared-sum block.
- Consumes the signed Q(N-FRAC_WIDTH).FRAC_WIDTH sum of squares and produces the vector length in the same format.
- Used by collision and normalisation logic.
- Digit-by-digit (two radicand bits per cycle) integer square root.
- Valid/ready handshakes on both sides; one operation in flight at a time.

Parameters:
- N, 32, total word width of input and output (two's complement fixed point)
- FRAC_WIDTH, 30, fractional bits of input and output; N+FRAC_WIDTH must be even
- ITER, (N+FRAC_WIDTH)/2, iteration count (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  sum presented
- in_ready  output  1  block idle, will accept sum
- sum  input  N  signed fixed-point sum of squares
- out_valid  output  1  root/err valid
- out_ready  input  1  consumer accepts result
- root  output  N  signed fixed-point length, always non-negative
- err  output  1  input was negative

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values (async, immediate): state IDLE, in_ready=1, out_valid=0, root=0, err=0, iteration counter=0, internal remainder/radicand/partial root=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, sum is captured and the block moves to CALC with counter=0.
  - If sum[N-1]=1 (negative), err_pending=1 and the radicand is forced to 0.
  - Otherwise radicand = {sum[N-2:0], FRAC_WIDTH zeros}, width N+FRAC_WIDTH.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge performs one iteration:
    - rem = (rem<<2) | top two radicand bits; radicand <<= 2.
    - trial = (root_p<<2)|1.
    - If rem >= trial: rem -= trial, root_p = (root_p<<1)|1; else root_p <<= 1.
  - The counter increments each edge.
  - On the edge completing iteration ITER: root <= zero-extended root_p, err <= err_pending, out_valid <= 1, state DONE.
- Latency: out_valid rises exactly ITER clock edges after the accepting edge (31 for defaults). Fixed latency; no early exit for zero input.
- Arithmetic:
  - root = floor(sqrt(sum * 2^FRAC_WIDTH)), i.e. truncation, never rounded up.
  - Result fits in N-1 bits, so root[N-1]=0 always.
  - Internal rem/trial width is ITER+2 bits; no overflow permitted.
- DONE:
  - out_valid=1; root and err held stable until an edge with out_ready=1, then state IDLE, out_valid=0.
  - root/err keep their values after the handshake until the next result.
  - in_ready stays 0 in DONE; a new sum is not accepted in the same cycle as the output handshake. Minimum issue interval is ITER+2 cycles.
- in_valid is ignored outside IDLE; sum is sampled only on the accepting edge, so later changes have no effect.
- out_ready is ignored outside DONE.
- Reset mid-CALC or mid-DONE aborts the operation: no out_valid pulse, all state cleared as above.

Test Plan:
- Reset asserted asynchronously between clock edges -> in_ready=1, out_valid=0, root=0, err=0 immediately.
- sum=0x40000000 (1.0) accepted, out_ready=1 -> out_valid exactly 31 edges after accept, root=0x40000000, err=0; block back in IDLE next edge.
- sum=0x10000000 (0.25) -> root=0x20000000 (0.5). sum=0 -> root=0. sum=0x7FFFFFFF -> root=0x5A827999 (truncated sqrt(2)).
- sum=0x80000000 (negative) -> err=1, root=0 after 31 edges. Next op with sum=0x40000000 -> err=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> root/err stable, in_ready=0 throughout; in_valid pulses with other sums ignored.
- Reset asserted 12 cycles into CALC, then released -> no out_valid. A fresh sum=0x10000000 gives root=0x20000000 with normal latency.

Source files
------------

// File: rtl/vec_len_sqrt.sv
// Sequential fixed-point square root for the squared-sum path.
// Each CALC cycle retires two radicand bits; one operation is in flight at a time.
module vec_len_sqrt #(
    parameter int N          = 32,
    parameter int FRAC_WIDTH = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] root,
    output logic         err
);
    localparam int ITER = (N + FRAC_WIDTH) / 2;
    localparam int RW   = N + FRAC_WIDTH;
    localparam int CW   = $clog2(ITER);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   rad;
    logic [ITER+1:0] rem;
    logic [ITER-1:0] root_p;
    logic            err_pending;

    logic [ITER+1:0] rem_sh, trial;
    logic            take;

    // rem stays below 2*root_p+1, so dropping its top two bits on the shift loses nothing
    always_comb begin
        rem_sh = {rem[ITER-1:0], rad[RW-1:RW-2]};
        trial  = {root_p, 2'b01};
        take   = (rem_sh >= trial);
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rad         <= '0;
            rem         <= '0;
            root_p      <= '0;
            err_pending <= 1'b0;
            out_valid   <= 1'b0;
            root        <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state       <= CALC;
                        cnt         <= '0;
                        rem         <= '0;
                        root_p      <= '0;
                        err_pending <= sum[N-1];
                        rad         <= sum[N-1] ? '0 : {1'b0, sum[N-2:0], {FRAC_WIDTH{1'b0}}};
                    end
                end
                CALC: begin
                    rad    <= rad << 2;
                    rem    <= take ? (rem_sh - trial) : rem_sh;
                    root_p <= {root_p[ITER-2:0], take};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        root      <= {{(N-ITER){1'b0}}, root_p[ITER-2:0], take};
                        err       <= err_pending;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_len_sqrt.sv
// Scoreboard bench for vec_len_sqrt: directed sums with hand-computed roots,
// latency, backpressure and reset-abort checks.
module tb_vec_len_sqrt;
    localparam int N   = 32;
    localparam int LAT = 31;

    typedef struct {
        logic [N-1:0] root;
        logic         err;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] sum = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] root;
    logic         err;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    vec_len_sqrt #(.N(N), .FRAC_WIDTH(30)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .out_valid(out_valid), .out_ready(out_ready),
        .root(root), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [N-1:0] s, input logic [N-1:0] r, input logic e);
        exp_t x;
        int   k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("issue_timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        sum      = s;
        @(posedge clk);
        #1;
        x.root = r;
        x.err  = e;
        x.acc  = cyc;
        q.push_back(x);
        in_valid = 1'b0;
        sum      = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: latency on the rising out_valid, data on handshake, stability while stalled
    initial begin : monitor
        logic prev_ov;
        logic hs_last;
        prev_ov = 1'b0;
        hs_last = 1'b0;
        while (!done) begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_ov = 1'b0;
                hs_last = 1'b0;
                continue;
            end
            if (hs_last) chk("idle_after_hs", 64'(in_ready), 64'd1);
            hs_last = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    if (!prev_ov) chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
                    chk("in_ready_busy", 64'(in_ready), 64'd0);
                    if (out_ready) begin
                        chk("root", 64'(root), 64'(q[0].root));
                        chk("err", 64'(err), 64'(q[0].err));
                        void'(q.pop_front());
                        hs_last = 1'b1;
                    end else begin
                        chk("root_stall", 64'(root), 64'(q[0].root));
                        chk("err_stall", 64'(err), 64'(q[0].err));
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin : stim
        int k;
        #3 reset = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_root", 64'(root), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        #20 reset = 1'b0;
        out_ready = 1'b1;

        issue(32'h4000_0000, 32'h4000_0000, 1'b0); drain();
        issue(32'h1000_0000, 32'h2000_0000, 1'b0); drain();
        issue(32'h0000_0000, 32'h0000_0000, 1'b0); drain();
        issue(32'h7FFF_FFFF, 32'h5A82_7999, 1'b0); drain();
        issue(32'h8000_0000, 32'h0000_0000, 1'b1); drain();
        issue(32'h4000_0000, 32'h4000_0000, 1'b0); drain();
        issue(32'h0000_0001, 32'h0000_8000, 1'b0); drain();
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1); drain();

        // Backpressure with ignored input pulses while the result is held
        out_ready = 1'b0;
        issue(32'h1000_0000, 32'h2000_0000, 1'b0);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) chk("bp_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            sum      = 32'h0CAF_E000 + 32'(i);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Second backpressure on an error result
        out_ready = 1'b0;
        issue(32'h9000_0000, 32'h0000_0000, 1'b1);
        repeat (LAT + 5) @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset mid-CALC aborts without a result
        issue(32'h4000_0000, 32'h4000_0000, 1'b0);
        repeat (12) @(posedge clk);
        #3 reset = 1'b1;
        void'(q.pop_back());
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_root", 64'(root), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        #15 reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'h1000_0000, 32'h2000_0000, 1'b0); drain();

        done = 1'b1;
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
